// File: rtl/midi_note_rx.sv
// MIDI serial receiver and Note On/Off parser driving a monophonic, last-note-priority
// note/velocity/gate interface for one selectable channel.
module midi_note_rx #(
  parameter int CLKS_PER_BIT = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_evt,
  output logic       frame_err
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    P_NO_STATUS, P_WAIT_D1, P_WAIT_D2
  } p_state_t;

  logic             rx_meta, rxs, rxs_d;
  rx_state_t        rx_st, rx_st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       byte_p0, byte_nx;
  logic             vld_p0, vld_nx;
  logic             ferr_p0, ferr_nx;

  p_state_t   p_st, p_nx;
  logic       run_on, run_nx;
  logic [6:0] key, key_nx;
  logic [6:0] note_p1, note_nx;
  logic [6:0] vel_p1, vel_nx;
  logic       gate_p1, gate_nx;
  logic       evt_p1, evt_nx;

  // Line synchronizer; the line idles high so the flops reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      vld_p0  <= 1'b0;
      ferr_p0 <= 1'b0;
    end else begin
      rx_st   <= rx_st_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      vld_p0  <= vld_nx;
      ferr_p0 <= ferr_nx;
    end
  end

  always_ff @(posedge clk) begin
    byte_p0 <= byte_nx;
  end

  always_comb begin
    rx_st_nx = rx_st;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    byte_nx  = byte_p0;
    vld_nx   = 1'b0;
    ferr_nx  = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        if (rxs_d && !rxs) begin
          rx_st_nx = RX_START;
          cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx = '0;
          bit_nx = '0;
          rx_st_nx = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nx  = '0;
          byte_nx = {rxs, byte_p0[7:1]};
          if (bit_idx == 3'd7) rx_st_nx = RX_STOP;
          else                 bit_nx   = bit_idx + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nx = '0;
          if (rxs) begin
            vld_nx   = 1'b1;
            rx_st_nx = RX_IDLE;
          end else begin
            ferr_nx  = 1'b1;
            rx_st_nx = RX_WAIT_HIGH;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs) rx_st_nx = RX_IDLE;
      end
      default: rx_st_nx = RX_IDLE;
    endcase
  end

  // ---- byte stage p0 -> parser/output stage p1 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      p_st    <= P_NO_STATUS;
      run_on  <= 1'b0;
      key     <= '0;
      note_p1 <= '0;
      vel_p1  <= '0;
      gate_p1 <= 1'b0;
      evt_p1  <= 1'b0;
    end else begin
      p_st    <= p_nx;
      run_on  <= run_nx;
      key     <= key_nx;
      note_p1 <= note_nx;
      vel_p1  <= vel_nx;
      gate_p1 <= gate_nx;
      evt_p1  <= evt_nx;
    end
  end

  always_comb begin
    p_nx    = p_st;
    run_nx  = run_on;
    key_nx  = key;
    note_nx = note_p1;
    vel_nx  = vel_p1;
    gate_nx = gate_p1;
    evt_nx  = 1'b0;
    if (vld_p0) begin
      if (byte_p0[7]) begin
        // Real-time bytes (0xF8-0xFF) pass through without touching parser state.
        if (byte_p0[7:3] != 5'b11111) begin
          if (byte_p0[7:5] == 3'b100 && byte_p0[3:0] == channel) begin
            run_nx = byte_p0[4];
            p_nx   = P_WAIT_D1;
          end else begin
            run_nx = 1'b0;
            p_nx   = P_NO_STATUS;
          end
        end
      end else begin
        case (p_st)
          P_WAIT_D1: begin
            key_nx = byte_p0[6:0];
            p_nx   = P_WAIT_D2;
          end
          P_WAIT_D2: begin
            p_nx = P_WAIT_D1;
            if (run_on && byte_p0[6:0] != 7'd0) begin
              note_nx = key;
              vel_nx  = byte_p0[6:0];
              gate_nx = 1'b1;
              evt_nx  = 1'b1;
            end else if (gate_p1 && key == note_p1) begin
              gate_nx = 1'b0;
              evt_nx  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign note      = note_p1;
  assign velocity  = vel_p1;
  assign gate      = gate_p1;
  assign note_evt  = evt_p1;
  assign frame_err = ferr_p0;

endmodule

// File: tb/tb_midi_note_rx.sv
// Randomized bench for midi_note_rx: directed MIDI sequences plus random byte streams
// compared against a message-level reference model.
module tb_midi_note_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       gate;
  logic       note_evt;
  logic       frame_err;

  midi_note_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .channel(channel),
    .note(note), .velocity(velocity), .gate(gate),
    .note_evt(note_evt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  int fe_cnt = 0;

  // Reference model state: message-level view of the receiver.
  int m_note = 0, m_vel = 0, m_gate = 0;
  int m_status = 0;  // 0 none, 8 note off, 9 note on
  int m_have_key = 0;
  int m_key = 0;
  int exp_ev = 0, exp_fe = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (note_evt)  ev_cnt++;
      if (frame_err) fe_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_note = 0; m_vel = 0; m_gate = 0;
    m_status = 0; m_have_key = 0; m_key = 0;
  endtask

  task automatic model_byte(input int b);
    if (b >= 'hF8) return;
    if (b >= 'h80) begin
      if ((b / 16 == 8 || b / 16 == 9) && (b % 16) == int'(channel)) begin
        m_status = b / 16;
        m_have_key = 0;
      end else begin
        m_status = 0;
      end
    end else if (m_status != 0) begin
      if (!m_have_key) begin
        m_key = b;
        m_have_key = 1;
      end else begin
        m_have_key = 0;
        if (m_status == 9 && b > 0) begin
          m_note = m_key; m_vel = b; m_gate = 1; exp_ev++;
        end else if (m_gate == 1 && m_key == m_note) begin
          m_gate = 0; exp_ev++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_note"}, int'(note), m_note);
    chk({tag, "_vel"}, int'(velocity), m_vel);
    chk({tag, "_gate"}, int'(gate), m_gate);
    chk({tag, "_evts"}, ev_cnt, exp_ev);
    chk({tag, "_ferr"}, fe_cnt, exp_fe);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = 1'b1;
      rst = 1'b0;
    end
  endtask

  // Drives one 10-bit frame; rst pulses for one cycle inside frame slot rst_slot (-1 = never).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_slot);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx_in = fr[j];
        rst = (j == rst_slot && c == 2);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    send_frame(b, 1'b1, -1);
    idle(2 * CPB);
    model_byte(int'(b));
    check_all(tag);
  endtask

  task automatic send_bad_stop(input logic [7:0] b, input string tag);
    send_frame(b, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(2 * CPB);
    exp_fe++;
    check_all(tag);
  endtask

  task automatic glitch(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(2 * CPB);
    check_all(tag);
  endtask

  initial begin
    int r;
    int cat;
    logic [7:0] b;
    rst = 1'b1;
    rx_in = 1'b1;
    channel = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_note", int'(note), 0);
    chk("rst_vel", int'(velocity), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_evt", int'(note_evt), 0);
    chk("rst_ferr", int'(frame_err), 0);
    idle(CPB);

    send(8'h90, "on_s"); send(8'h3C, "on_k"); send(8'h64, "on_v");
    chk("tp1_note", int'(note), 60);
    chk("tp1_vel", int'(velocity), 100);
    chk("tp1_evts", ev_cnt, 1);

    send(8'h80, "off_s"); send(8'h3C, "off_k"); send(8'h00, "off_v");
    chk("tp2_gate", int'(gate), 0);
    chk("tp2_note", int'(note), 60);
    send(8'h90, "on0_s"); send(8'h40, "on0_k"); send(8'h00, "on0_v");
    chk("tp2_evts", ev_cnt, 2);

    send(8'h90, "rs_s"); send(8'h3C, "rs_k1"); send(8'h64, "rs_v1");
    send(8'h3E, "rs_k2"); send(8'h50, "rs_v2");
    chk("tp3_note", int'(note), 62);
    chk("tp3_vel", int'(velocity), 80);
    send(8'h3E, "rs_k3"); send(8'h00, "rs_v3");
    chk("tp3_gate", int'(gate), 0);

    send(8'h91, "ch1_s"); send(8'h3C, "ch1_k"); send(8'h64, "ch1_v");
    send(8'h90, "rt_s"); send(8'h45, "rt_k"); send(8'hF8, "rt_rt"); send(8'h7F, "rt_v");
    chk("tp4_note", int'(note), 69);
    chk("tp4_vel", int'(velocity), 127);

    send_bad_stop(8'h90, "ferr");
    chk("tp5_fe", fe_cnt, 1);
    send(8'h90, "fe_s"); send(8'h30, "fe_k"); send(8'h10, "fe_v");
    chk("tp5_note", int'(note), 48);
    glitch("glitch");

    send(8'h90, "mr_s"); send(8'h3C, "mr_k");
    send_frame(8'h64, 1'b1, 4);
    idle(12 * CPB);
    model_reset();
    check_all("midrst");
    send(8'h90, "ar_s"); send(8'h3C, "ar_k"); send(8'h64, "ar_v");
    chk("tp6_note", int'(note), 60);
    chk("tp6_gate", int'(gate), 1);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 99) < 5) channel = 4'($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 6) begin
        send_bad_stop(8'($urandom_range(0, 255)), "rnd_ferr");
      end else if (r < 10) begin
        glitch("rnd_glitch");
      end else begin
        cat = $urandom_range(0, 99);
        if (cat < 20)      b = ($urandom_range(0, 1) ? 8'h90 : 8'h80) | 8'(channel);
        else if (cat < 27) b = 8'h90 | 8'(($urandom_range(0, 15) + 1 + channel) % 16);
        else if (cat < 33) b = 8'($urandom_range('hA0, 'hF7));
        else if (cat < 40) b = 8'($urandom_range('hF8, 'hFF));
        else if (cat < 50) b = 8'h00;
        else if (cat < 80) b = 8'($urandom_range(60, 63));
        else               b = 8'($urandom_range(0, 127));
        send(b, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
